ltrt_piso_tx: RTL and testbench

- Parallel-in, serial-out transmitter; the transmit end of the 8-bit left/right serial shift-register link.
- Accepts a parallel word over a valid/ready handshake and shifts it out one bit per enabled cycle.
- Serial order is selectable per word: MSB-first (left shift) or LSB-first (right shift).
- Sits in front of the serial-in receive shift register and produces the `din` stream it consumes.

---
 rtl/ltrt_pkg.sv | 18 +
 rtl/ltrt_bitcnt.sv | 31 +++
 rtl/ltrt_piso_tx.sv | 139 +++++++++++++
 tb/tb_ltrt_piso_tx.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/ltrt_pkg.sv
// Shared definitions for the ltrt serial shift-register link: FSM state
// encodings, shift-direction constants and the default word width. Used by
// the transmitter, the receive-side register and their benches.
package ltrt_pkg;

  localparam int LTRT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_t;

  // Shift direction captured with each word
  localparam logic DIR_LEFT  = 1'b1;  // MSB first
  localparam logic DIR_RIGHT = 1'b0;  // LSB first

endpackage : ltrt_pkg

// File: rtl/ltrt_bitcnt.sv
// Bit counter for serial word framing: synchronous clear, count enable and a
// terminal-count flag comparing against a supplied last index. The counter
// is cleared on every load, so it never needs to wrap.
module ltrt_bitcnt #(
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] last,
  output logic [CNT_W-1:0] cnt,
  output logic             tc
);

  // Count enabled bits; clear has priority over enable
  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign tc = (cnt == last);

endmodule : ltrt_bitcnt

// File: rtl/ltrt_piso_tx.sv
// Parallel-in serial-out transmitter for the ltrt link. Accepts a word over
// ld_valid/ld_ready, then presents it one bit per shift_en cycle, MSB-first
// or LSB-first as selected by sl at load time.
// Optional feature macro: LTRT_PISO_PARITY_EN -- when defined, an even-parity
// bit captured at load follows the data bits as one extra serial bit.
module ltrt_piso_tx
  import ltrt_pkg::*;
#(
  parameter int WIDTH = LTRT_WIDTH,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ld_valid,
  output logic             ld_ready,
  input  logic [WIDTH-1:0] ld_data,
  input  logic             sl,
  input  logic             shift_en,
  output logic             sout,
  output logic             sout_valid,
  output logic             busy,
  output logic             done
);

`ifdef LTRT_PISO_PARITY_EN
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH);
`else
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);
`endif

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] shreg;
  logic             dir;
  logic [CNT_W-1:0] cnt;
  logic             cnt_tc;
  logic             accept;
  logic             advance;
  logic             data_bit;

`ifdef LTRT_PISO_PARITY_EN
  logic             par;
`endif

  assign accept   = (state == ST_IDLE) && ld_valid;
  assign advance  = (state == ST_SHIFT) && shift_en;
  assign data_bit = (dir == DIR_LEFT) ? shreg[WIDTH-1] : shreg[0];

  ltrt_bitcnt #(
    .CNT_W (CNT_W)
  ) u_bitcnt (
    .clk   (clk),
    .reset (reset),
    .clr   (accept),
    .en    (advance),
    .last  (LAST),
    .cnt   (cnt),
    .tc    (cnt_tc)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Shift register and per-word direction: load on accept, shift on enable
  always_ff @(posedge clk) begin
    if (!reset) begin
      shreg <= '0;
      dir   <= DIR_RIGHT;
    end else if (accept) begin
      shreg <= ld_data;
      dir   <= sl;
    end else if (advance) begin
      if (dir == DIR_LEFT) begin
        shreg <= {shreg[WIDTH-2:0], 1'b0};
      end else begin
        shreg <= {1'b0, shreg[WIDTH-1:1]};
      end
    end
  end

`ifdef LTRT_PISO_PARITY_EN
  // Even parity of the accepted word, sent after the data bits
  always_ff @(posedge clk) begin
    if (!reset) begin
      par <= 1'b0;
    end else if (accept) begin
      par <= ^ld_data;
    end
  end
`endif

  // Next-state and output decode
  // NOTE: every output and state_nxt gets a default first, so no path through
  // the case statement can leave a signal unassigned and infer a latch.
  always_comb begin
    state_nxt  = state;
    ld_ready   = 1'b0;
    sout       = 1'b0;
    sout_valid = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      ST_IDLE: begin
        ld_ready = 1'b1;
        if (ld_valid) begin
          state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        sout_valid = 1'b1;
        busy       = 1'b1;
`ifdef LTRT_PISO_PARITY_EN
        sout       = cnt_tc ? par : data_bit;
`else
        sout       = data_bit;
`endif
        if (shift_en && cnt_tc) begin
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: begin
        // Unused encoding 2'b11 falls back to IDLE
        state_nxt = ST_IDLE;
      end
    endcase
  end

endmodule : ltrt_piso_tx

// File: tb/tb_ltrt_piso_tx.sv
// Directed bench for ltrt_piso_tx. Expected serial sequences and parity bits
// are written out by hand for each vector. Outputs are checked 1 ns after
// each rising edge, as the vector {sout_valid, sout, busy, done, ld_ready}.
// Honors LTRT_PISO_PARITY_EN to expect the extra parity bit.
module tb_ltrt_piso_tx;

`ifdef LTRT_PISO_PARITY_EN
  localparam int NB = 9;
`else
  localparam int NB = 8;
`endif

  logic       clk;
  logic       reset;
  logic       ld_valid;
  logic       ld_ready;
  logic [7:0] ld_data;
  logic       sl;
  logic       shift_en;
  logic       sout;
  logic       sout_valid;
  logic       busy;
  logic       done;

  int n_checks;
  int n_errors;
  int done_cnt;

  ltrt_piso_tx #(
    .WIDTH (8),
    .CNT_W (6)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .ld_valid   (ld_valid),
    .ld_ready   (ld_ready),
    .ld_data    (ld_data),
    .sl         (sl),
    .shift_en   (shift_en),
    .sout       (sout),
    .sout_valid (sout_valid),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count done pulses seen at clock edges
  always @(posedge clk) begin
    if (reset && done) done_cnt <= done_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [4:0] obs();
    return {sout_valid, sout, busy, done, ld_ready};
  endfunction

  // Send one word. seq holds the expected serial bits, first-sent bit in
  // seq[7]; par is the expected parity bit (only checked with the option on).
  task automatic send_word(input string tag, input logic [7:0] data, input logic sl_i,
                           input logic [7:0] seq, input logic par,
                           input int stall_at, input int stall_len,
                           input bit hold_valid, input int abort_at);
    logic b;
    ld_data  = data;
    sl       = sl_i;
    ld_valid = 1'b1;
    shift_en = 1'b1;
    check({tag, "_rdy"}, 32'(obs()), 32'(5'b00001));
    tick();
    if (!hold_valid) ld_valid = 1'b0;
    for (int k = 0; k < NB; k++) begin
      b = (k < 8) ? seq[7-k] : par;
      if (hold_valid) begin
        ld_data = ~data ^ 8'(k);
        sl      = ~sl_i;
      end
      if (k == stall_at) begin
        shift_en = 1'b0;
        for (int s = 0; s < stall_len; s++) begin
          check($sformatf("%s_hold%0d_%0d", tag, k, s), 32'(obs()), 32'({1'b1, b, 3'b100}));
          tick();
        end
        shift_en = 1'b1;
      end
      check($sformatf("%s_b%0d", tag, k), 32'(obs()), 32'({1'b1, b, 3'b100}));
      if (k == abort_at) begin
        reset = 1'b0;
        tick();
        check({tag, "_abort"}, 32'(obs()), 32'(5'b00001));
        reset    = 1'b1;
        ld_valid = 1'b0;
        return;
      end
      tick();
    end
    check({tag, "_done"}, 32'(obs()), 32'(5'b00110));
    tick();
    check({tag, "_idle"}, 32'(obs()), 32'(5'b00001));
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    done_cnt = 0;
    reset    = 1'b0;
    ld_valid = 1'b0;
    ld_data  = 8'h00;
    sl       = 1'b0;
    shift_en = 1'b0;
    repeat (2) tick();
    check("reset_state", 32'(obs()), 32'(5'b00001));
    reset = 1'b1;
    tick();
    check("idle_hold", 32'(obs()), 32'(5'b00001));

    //        tag        data   sl    seq    par  stall  len hold abort
    send_word("a5_msb",  8'hA5, 1'b1, 8'hA5, 1'b0, -1,    0,  0,  -1);
    send_word("a5_lsb",  8'hA5, 1'b0, 8'hA5, 1'b0, -1,    0,  0,  -1);
    send_word("01_lsb",  8'h01, 1'b0, 8'h80, 1'b1, -1,    0,  0,  -1);
    send_word("f0_stl",  8'hF0, 1'b1, 8'hF0, 1'b0,  2,    3,  0,  -1);
    send_word("96_hold", 8'h96, 1'b1, 8'h96, 1'b0, -1,    0,  1,  -1);
    send_word("81_next", 8'h81, 1'b0, 8'h81, 1'b0, -1,    0,  0,  -1);
    send_word("c3_rst",  8'hC3, 1'b1, 8'hC3, 1'b0, -1,    0,  0,   4);
    send_word("3c_msb",  8'h3C, 1'b1, 8'h3C, 1'b0, -1,    0,  0,  -1);
    send_word("07_msb",  8'h07, 1'b1, 8'h07, 1'b1, -1,    0,  0,  -1);

    tick();
    check("idle_end", 32'(obs()), 32'(5'b00001));
    check("done_pulses", 32'(done_cnt), 32'd8);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_ltrt_piso_tx
